// File: rtl/state_seq_pkg.sv
// rtl/state_seq_pkg.sv - shared encodings, command type and step arithmetic for state_seq_gen
package state_seq_pkg;

   localparam logic [1:0] S0        = 2'b00;
   localparam logic [1:0] S1        = 2'b01;
   localparam logic [1:0] S2        = 2'b10;
   localparam logic [1:0] S_ILLEGAL = 2'b11;

   // Hold width carried in the queued command; the top's CNT_W must equal this.
   localparam int CMD_HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      HOLD = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic [1:0]            state;
      logic [CMD_HOLD_W-1:0] hold;
   } cmd_t;

   // Number of din=1 cycles to walk the ring from cur to target (both in 0..2).
   function automatic logic [1:0] steps_to(input logic [1:0] target, input logic [1:0] cur);
      if (target >= cur) return target - cur;
      return target + 2'd3 - cur;
   endfunction

   function automatic logic [1:0] ring_next(input logic [1:0] cur);
      return (cur == S2) ? S0 : cur + 2'd1;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous FIFO with full/empty flags and async active-low reset
module cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/state_seq_gen.sv
// rtl/state_seq_gen.sv - serialises goto-state/hold commands into din and checks dout against a model
module state_seq_gen
   import state_seq_pkg::*;
#(
   parameter int CNT_W      = CMD_HOLD_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_state,
   input  logic [CNT_W-1:0] cmd_hold,
   input  logic             dut_rst_i,
   input  logic             dout_i,
   output logic             din_o,
   output logic             busy,
   output logic [1:0]       model_state,
   output logic             done,
   output logic             cmd_err,
   output logic             abort,
   output logic             mismatch
);
   cmd_t        cmd_in, cmd_head;
   logic        fifo_full, fifo_empty, pop;

   ctrl_state_e state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [1:0]  model_q, model_d;
   logic [1:0]  steps;
   logic        din_q, din_d;
   logic        done_q, done_d, err_q, err_d, abort_q, abort_d;
   logic        mismatch_q, mismatch_d;

   assign cmd_in = '{state: cmd_state, hold: cmd_hold};

   cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (cmd_valid),
      .wdata_i (cmd_in),
      .pop_i   (pop),
      .rdata_o (cmd_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      model_d = model_q;
      if (dut_rst_i)  model_d = S0;
      else if (din_q) model_d = ring_next(model_q);
      mismatch_d = mismatch_q | (!dut_rst_i && (dout_i != (model_q == S2)));
   end

   // Steps use the model value this edge will produce, so a downstream reset
   // coinciding with a pop is already accounted for.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      hold_d  = hold_q;
      din_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      abort_d = 1'b0;
      pop     = 1'b0;
      steps   = steps_to(cmd_head.state, model_d);
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (cmd_head.state == S_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  hold_d = cmd_head.hold;
                  step_d = steps;
                  if (steps != 2'd0) begin
                     state_d = STEP;
                     din_d   = 1'b1;
                  end else if (cmd_head.hold != '0) begin
                     state_d = HOLD;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
         end
         STEP: begin
            if (dut_rst_i) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (step_q == 2'd1) begin
               step_d = 2'd0;
               if (hold_q != '0) begin
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               step_d = step_q - 2'd1;
               din_d  = 1'b1;
            end
         end
         HOLD: begin
            if (dut_rst_i) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (hold_q == 1'b1) begin
               hold_d  = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         step_q     <= '0;
         hold_q     <= '0;
         model_q    <= S0;
         din_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         abort_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         model_q    <= model_d;
         din_q      <= din_d;
         done_q     <= done_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign cmd_ready   = !fifo_full;
   assign busy        = (state_q != IDLE) || !fifo_empty;
   assign din_o       = din_q;
   assign model_state = model_q;
   assign done        = done_q;
   assign cmd_err     = err_q;
   assign abort       = abort_q;
   assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_state_seq_gen.sv
// tb/tb_state_seq_gen.sv - randomized self-checking bench for state_seq_gen with a ones-counter downstream
module tb_state_seq_gen;
   localparam int CNT_W      = 8;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cmd_valid = 1'b0;
   logic [1:0] cmd_state = 2'd0;
   logic [CNT_W-1:0] cmd_hold = '0;
   logic dut_rst_i = 1'b1;
   logic force_dout = 1'b0;
   logic cmd_ready, din_o, busy, done, cmd_err, abort, mismatch, dout_i;
   logic [1:0] model_state;

   int ds = 0;
   int n_assert = 0;
   int n_fail = 0;
   int exp_pos = 0;
   int bst [8];
   int bhd [8];

   state_seq_gen #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_state(cmd_state), .cmd_hold(cmd_hold), .dut_rst_i(dut_rst_i),
      .dout_i(dout_i), .din_o(din_o), .busy(busy), .model_state(model_state),
      .done(done), .cmd_err(cmd_err), .abort(abort), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   // Downstream ones-counting machine: sync active-high reset, counts din=1 mod 3.
   always @(posedge clk) begin
      if (dut_rst_i)  ds <= 0;
      else if (din_o) ds <= (ds + 1) % 3;
   end
   assign dout_i = force_dout | (ds == 2);

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // Walks one command from its pop cycle (k=0) to its completion cycle.
   task automatic expect_cmd(input int st, input int hold, input bit chained);
      bit illegal;
      int steps, last, ones, em;
      logic ed;
      illegal = (st == 3);
      steps   = illegal ? 0 : (st - exp_pos + 3) % 3;
      last    = illegal ? 1 : steps + hold + 1;
      if (!chained) @(negedge clk);
      for (int k = 0; k <= last; k++) begin
         if (k > 0) @(negedge clk);
         ed   = (k >= 1 && k <= steps);
         ones = (k <= 1) ? 0 : ((k - 1 < steps) ? k - 1 : steps);
         em   = (exp_pos + ones) % 3;
         n_assert++;
         if (din_o !== ed) begin
            n_fail++;
            $display("FAIL din cmd=(%0d,%0d) k=%0d got %0b exp %0b", st, hold, k, din_o, ed);
         end
         n_assert++;
         if (model_state !== 2'(em)) begin
            n_fail++;
            $display("FAIL model cmd=(%0d,%0d) k=%0d got %0d exp %0d", st, hold, k, model_state, em);
         end
         if (k == 0) begin
            n_assert++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_pop got %0b exp 1", busy);
            end
         end else begin
            n_assert++;
            if (done !== (k == last && !illegal)) begin
               n_fail++;
               $display("FAIL done cmd=(%0d,%0d) k=%0d got %0b exp %0b", st, hold, k, done, (k == last && !illegal));
            end
            n_assert++;
            if (cmd_err !== (k == last && illegal)) begin
               n_fail++;
               $display("FAIL cmd_err cmd=(%0d,%0d) k=%0d got %0b exp %0b", st, hold, k, cmd_err, (k == last && illegal));
            end
            n_assert++;
            if (abort !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle k=%0d got %0b exp 0", k, abort);
            end
         end
      end
      n_assert++;
      if (mismatch !== 1'b0) begin
         n_fail++;
         $display("FAIL mismatch_clean cmd=(%0d,%0d) got %0b exp 0", st, hold, mismatch);
      end
      if (!illegal) exp_pos = st;
   endtask

   task automatic push_batch(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         cmd_state = 2'(bst[i]);
         cmd_hold  = CNT_W'(bhd[i]);
         cmd_valid = 1'b1;
         n_assert++;
         if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL batch_ready i=%0d got %0b exp 1", i, cmd_ready);
         end
         @(posedge clk);
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic run_batch(input int n);
      @(negedge clk);
      fork
         push_batch(n);
         begin
            @(posedge clk);
            for (int i = 0; i < n; i++) expect_cmd(bst[i], bhd[i], i > 0);
         end
      join
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_assert++;
      if ({din_o, model_state, done, cmd_err, abort, mismatch, busy} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b exp 00000000", {din_o, model_state, done, cmd_err, abort, mismatch, busy});
      end
      rst = 1'b1;
      @(negedge clk);
      dut_rst_i = 1'b0;
      @(negedge clk);
      n_assert++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release ready=%0b busy=%0b exp 1 0", cmd_ready, busy);
      end
      exp_pos = 0;
   endtask

   task automatic test_directed();
      bst[0] = 2; bhd[0] = 3;
      bst[1] = 1; bhd[1] = 0;
      bst[2] = 0; bhd[2] = 0;
      run_batch(3);
      bst[0] = 0; bhd[0] = 0;
      bst[1] = 3; bhd[1] = 5;
      run_batch(2);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin
            bst[i] = $urandom_range(0, 3);
            bhd[i] = $urandom_range(0, 6);
         end
         run_batch(4);
      end
   endtask

   task automatic test_back_to_back();
      int b;
      bst[0] = exp_pos; bhd[0] = 200;
      for (int i = 1; i < 6; i++) begin
         bst[i] = $urandom_range(0, 2);
         bhd[i] = $urandom_range(0, 4);
      end
      @(negedge clk);
      fork
         begin
            cmd_state = 2'(bst[0]);
            cmd_hold  = CNT_W'(bhd[0]);
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            repeat (3) @(negedge clk);
            for (int i = 1; i < 6; i++) begin
               if (i > 1) @(negedge clk);
               cmd_state = 2'(bst[i]);
               cmd_hold  = CNT_W'(bhd[i]);
               cmd_valid = 1'b1;
               n_assert++;
               if (cmd_ready !== (i < 5)) begin
                  n_fail++;
                  $display("FAIL b2b_ready i=%0d got %0b exp %0b", i, cmd_ready, (i < 5));
               end
               b = 0;
               while (!cmd_ready && b < 400) begin
                  @(negedge clk);
                  b++;
               end
               n_assert++;
               if (cmd_ready !== 1'b1) begin
                  n_fail++;
                  $display("FAIL b2b_accept_timeout i=%0d got %0b exp 1", i, cmd_ready);
               end
               @(posedge clk);
            end
            #1 cmd_valid = 1'b0;
         end
         begin
            @(posedge clk);
            for (int i = 0; i < 6; i++) expect_cmd(bst[i], bhd[i], i > 0);
         end
      join
   endtask

   task automatic test_abort();
      int a_st;
      a_st = (exp_pos + 1) % 3;
      @(negedge clk);
      cmd_state = 2'(a_st); cmd_hold = 8'd10; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_state = 2'd1; cmd_hold = 8'd2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_assert++;
      if (din_o !== 1'b0 || busy !== 1'b1 || model_state !== 2'(a_st)) begin
         n_fail++;
         $display("FAIL abort_pre din=%0b busy=%0b model=%0d exp 0 1 %0d", din_o, busy, model_state, a_st);
      end
      dut_rst_i = 1'b1;
      @(negedge clk);
      n_assert++;
      if (abort !== 1'b1 || done !== 1'b0 || din_o !== 1'b0 || model_state !== 2'd0) begin
         n_fail++;
         $display("FAIL abort_pulse abort=%0b done=%0b din=%0b model=%0d exp 1 0 0 0", abort, done, din_o, model_state);
      end
      dut_rst_i = 1'b0;
      exp_pos = 0;
      expect_cmd(1, 2, 1'b1);
   endtask

   task automatic test_mismatch_rst();
      bst[0] = 0; bhd[0] = 0;
      run_batch(1);
      @(negedge clk);
      force_dout = 1'b1;
      @(negedge clk);
      n_assert++;
      if (mismatch !== 1'b1) begin
         n_fail++;
         $display("FAIL mismatch_set got %0b exp 1", mismatch);
      end
      force_dout = 1'b0;
      repeat (3) @(negedge clk);
      n_assert++;
      if (mismatch !== 1'b1) begin
         n_fail++;
         $display("FAIL mismatch_sticky got %0b exp 1", mismatch);
      end
      cmd_state = 2'd2; cmd_hold = 8'd50; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_state = 2'd1; cmd_hold = 8'd3;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b0;
      dut_rst_i = 1'b1;
      #1;
      n_assert++;
      if ({mismatch, din_o, busy, done, model_state, cmd_ready} !== 7'b0000001) begin
         n_fail++;
         $display("FAIL async_rst got %b exp 0000001", {mismatch, din_o, busy, done, model_state, cmd_ready});
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      dut_rst_i = 1'b0;
      exp_pos = 0;
      n_assert++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fifo_cleared busy got %0b exp 0", busy);
      end
      bst[0] = 1; bhd[0] = 1;
      run_batch(1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
      test_mismatch_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
